frog_controller_param: RTL and testbench
========================================

Name: frog_controller_param

Overview:
Parametrised successor to the single-frog movement/collision block. Moves the frog on a configurable grid from debounced buttons and checks collisions against a packed bus of NUM_CARS car positions. Adds a respawn/invulnerability window, a game-over state, goal scoring with automatic respawn, and a restart input. Sits between the button debouncers/car generators and the display and score logic.

Parameters:
GRID_COLS, 20, grid width in cells
GRID_ROWS, 15, grid height in cells
COL_W, 5, column coordinate width (2^COL_W >= GRID_COLS)
ROW_W, 4, row coordinate width (2^ROW_W >= GRID_ROWS)
NUM_CARS, 16, number of car positions on the bus
START_LIVES, 3, lives at reset/restart (1..2^LIVES_W-1)
LIVES_W, 2, lives counter width
RESPAWN_CYCLES, 25000000, freeze/invulnerable length after a hit (>=1)
RESPAWN_W, 25, respawn counter width
SCORE_W, 8, score counter width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
btn_left  in  1  debounced level, move column -1
btn_down  in  1  debounced level, move row +1
btn_up  in  1  debounced level, move row -1
btn_right  in  1  debounced level, move column +1
restart  in  1  synchronous restart pulse
car_x_bus  in  NUM_CARS*COL_W  car i column at [i*COL_W +: COL_W]
car_y_bus  in  NUM_CARS*ROW_W  car i row at [i*ROW_W +: ROW_W]
frog_col  out  COL_W  frog column
frog_row  out  ROW_W  frog row
lives  out  LIVES_W  lives remaining
score  out  SCORE_W  goals reached
hit_pulse  out  1  one-cycle pulse on a collision
goal_pulse  out  1  one-cycle pulse on reaching row 0
invulnerable  out  1  high while in RESPAWN
game_over  out  1  high while in GAME_OVER

Behaviour:
- Reset (async) and restart (sync, highest priority among sync events): state=PLAY, frog_col=GRID_COLS/2, frog_row=GRID_ROWS-1 (the "start cell"), lives=START_LIVES, score=0, respawn counter=0, move_block=1, all pulses 0.
- States: PLAY, RESPAWN, GAME_OVER. All outputs are registered.
- move_block: cleared in any cycle with all four buttons low; set by every accepted move and on every entry to PLAY or RESPAWN. A held button therefore moves exactly one cell.
- PLAY move: if !move_block, priority left > down > up > right; a move is taken only if in bounds (col>0, row<GRID_ROWS-1, row>0, col<GRID_COLS-1 respectively). An out-of-bounds request is ignored and does not set move_block.
- Collision: in PLAY, hit = any i with frog_col==car_x[i] and frog_row==car_y[i], evaluated on the registered frog position. The frog's new position is therefore checked one cycle after the move. A hit overrides any move and goal in the same cycle.
- On a hit: hit_pulse=1 next cycle; lives decrements; frog goes to the start cell. If lives was 1, lives becomes 0 and the state becomes GAME_OVER. Otherwise the state becomes RESPAWN with counter=RESPAWN_CYCLES-1.
- Goal: in PLAY with no hit and frog_row==0, goal_pulse=1 next cycle; score increments, saturating at all-ones; frog goes to the start cell; move_block is set; the state stays PLAY.
- RESPAWN: buttons and collisions are ignored; invulnerable=1. The counter decrements each cycle; at 0 the next state is PLAY (move_block set). The window lasts exactly RESPAWN_CYCLES cycles.
- GAME_OVER: position is frozen at the start cell and lives=0. Only reset or restart exits this state; game_over=1.
- Restart asserted in any state, including mid-RESPAWN, takes effect next cycle and drops any pending pulse.
- Car coordinates outside the grid never match a valid frog position; no special handling is required.

Test Plan:
- Use RESPAWN_CYCLES=4 and NUM_CARS=4 for all scenarios.
- Move/hold: after reset, hold btn_left 10 cycles then release → frog_col 10→9 only. Then press btn_up → row 14→13. With frog at col 0, press btn_left → col stays 0.
- Priority: btn_left and btn_right pressed together at (10,14) → (9,14).
- Hit/respawn: place car0 at (10,13) and move up → next cycle hit_pulse=1, lives 3→2, frog at (10,14), invulnerable=1 for exactly 4 cycles. Buttons are ignored during that window. A car at (10,14) during RESPAWN causes no hit.
- Game over: three successive hits → lives=0, game_over=1. Buttons are ignored afterwards. A restart pulse → lives=3, score=0, PLAY, frog at (10,14).
- Goal: drive the frog to row 0 with no cars → goal_pulse=1, score 0→1, frog at (10,14). With SCORE_W=2 and score=3, a goal leaves score at 3.
- Async reset mid-RESPAWN (counter=2) → all outputs at reset values immediately, with no clock edge required.

Source files
------------

// File: rtl/frog_controller_param_if.sv
// Bundle of the button, car-bus and status signals around the frog controller.
// The master side drives buttons, restart and car positions; the slave side is the controller.
interface frog_controller_param_if #(
    parameter int unsigned COL_W    = 5,
    parameter int unsigned ROW_W    = 4,
    parameter int unsigned NUM_CARS = 16,
    parameter int unsigned LIVES_W  = 2,
    parameter int unsigned SCORE_W  = 8
);
    logic                         btn_left;
    logic                         btn_down;
    logic                         btn_up;
    logic                         btn_right;
    logic                         restart;
    logic [NUM_CARS*COL_W-1:0]    car_x_bus;
    logic [NUM_CARS*ROW_W-1:0]    car_y_bus;
    logic [COL_W-1:0]             frog_col;
    logic [ROW_W-1:0]             frog_row;
    logic [LIVES_W-1:0]           lives;
    logic [SCORE_W-1:0]           score;
    logic                         hit_pulse;
    logic                         goal_pulse;
    logic                         invulnerable;
    logic                         game_over;

    modport master (
        output btn_left, btn_down, btn_up, btn_right, restart, car_x_bus, car_y_bus,
        input  frog_col, frog_row, lives, score, hit_pulse, goal_pulse, invulnerable, game_over
    );

    modport slave (
        input  btn_left, btn_down, btn_up, btn_right, restart, car_x_bus, car_y_bus,
        output frog_col, frog_row, lives, score, hit_pulse, goal_pulse, invulnerable, game_over
    );
endinterface

// File: rtl/frog_controller_param.sv
// Frog movement, collision, respawn, goal scoring and game-over control.
// Moves one cell per button press, checks the registered frog position against
// NUM_CARS car positions, and sequences PLAY / RESPAWN / GAME_OVER.
module frog_controller_param #(
    parameter int unsigned GRID_COLS      = 20,
    parameter int unsigned GRID_ROWS      = 15,
    parameter int unsigned COL_W          = 5,
    parameter int unsigned ROW_W          = 4,
    parameter int unsigned NUM_CARS       = 16,
    parameter int unsigned START_LIVES    = 3,
    parameter int unsigned LIVES_W        = 2,
    parameter int unsigned RESPAWN_CYCLES = 25000000,
    parameter int unsigned RESPAWN_W      = 25,
    parameter int unsigned SCORE_W        = 8
) (
    input  logic clk,
    input  logic reset,
    frog_controller_param_if.slave bus
);

    localparam logic [COL_W-1:0]     StartCol   = COL_W'(GRID_COLS / 2);
    localparam logic [ROW_W-1:0]     StartRow   = ROW_W'(GRID_ROWS - 1);
    localparam logic [COL_W-1:0]     LastCol    = COL_W'(GRID_COLS - 1);
    localparam logic [LIVES_W-1:0]   InitLives  = LIVES_W'(START_LIVES);
    localparam logic [RESPAWN_W-1:0] RespawnTop = RESPAWN_W'(RESPAWN_CYCLES - 1);

    typedef enum logic [1:0] {StPlay, StRespawn, StGameOver} state_e;

    state_e                state_q, state_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [LIVES_W-1:0]    lives_q, lives_d;
    logic [SCORE_W-1:0]    score_q, score_d;
    logic [RESPAWN_W-1:0]  cnt_q, cnt_d;
    logic                  move_block_q, move_block_d;
    logic                  hit_q, hit_d;
    logic                  goal_q, goal_d;
    logic                  invul_q, invul_d;
    logic                  over_q, over_d;

    logic                  hit_any;
    logic                  btn_none;

    assign btn_none = ~(bus.btn_left | bus.btn_down | bus.btn_up | bus.btn_right);

    // Collision detect against the registered frog position.
    always_comb begin
        hit_any = 1'b0;
        for (int i = 0; i < NUM_CARS; i++) begin
            if (col_q == bus.car_x_bus[i*COL_W +: COL_W] &&
                row_q == bus.car_y_bus[i*ROW_W +: ROW_W]) begin
                hit_any = 1'b1;
            end
        end
    end

    // Next-state logic: restart first, then per-state behaviour.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        lives_d      = lives_q;
        score_d      = score_q;
        cnt_d        = cnt_q;
        move_block_d = move_block_q;
        hit_d        = 1'b0;
        goal_d       = 1'b0;

        // Releasing every button re-arms movement; entry/move below may set it again.
        if (btn_none) begin
            move_block_d = 1'b0;
        end

        if (bus.restart) begin
            state_d      = StPlay;
            col_d        = StartCol;
            row_d        = StartRow;
            lives_d      = InitLives;
            score_d      = '0;
            cnt_d        = '0;
            move_block_d = 1'b1;
        end else begin
            unique case (state_q)
                StPlay: begin
                    if (hit_any) begin
                        hit_d        = 1'b1;
                        lives_d      = lives_q - LIVES_W'(1);
                        col_d        = StartCol;
                        row_d        = StartRow;
                        move_block_d = 1'b1;
                        if (lives_q == LIVES_W'(1)) begin
                            state_d = StGameOver;
                        end else begin
                            state_d = StRespawn;
                            cnt_d   = RespawnTop;
                        end
                    end else if (row_q == '0) begin
                        goal_d       = 1'b1;
                        col_d        = StartCol;
                        row_d        = StartRow;
                        move_block_d = 1'b1;
                        if (score_q != '1) begin
                            score_d = score_q + SCORE_W'(1);
                        end
                    end else if (!move_block_q) begin
                        // Out-of-bounds requests fall through without blocking.
                        if (bus.btn_left && col_q != '0) begin
                            col_d        = col_q - COL_W'(1);
                            move_block_d = 1'b1;
                        end else if (bus.btn_down && row_q < StartRow) begin
                            row_d        = row_q + ROW_W'(1);
                            move_block_d = 1'b1;
                        end else if (bus.btn_up && row_q != '0) begin
                            row_d        = row_q - ROW_W'(1);
                            move_block_d = 1'b1;
                        end else if (bus.btn_right && col_q < LastCol) begin
                            col_d        = col_q + COL_W'(1);
                            move_block_d = 1'b1;
                        end
                    end
                end
                StRespawn: begin
                    if (cnt_q == '0) begin
                        state_d      = StPlay;
                        move_block_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - RESPAWN_W'(1);
                    end
                end
                StGameOver: begin
                    col_d   = StartCol;
                    row_d   = StartRow;
                    lives_d = '0;
                end
                default: begin
                    state_d = StPlay;
                end
            endcase
        end

        invul_d = (state_d == StRespawn);
        over_d  = (state_d == StGameOver);
    end

    // State and output registers with asynchronous reset to the start condition.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StPlay;
            col_q        <= StartCol;
            row_q        <= StartRow;
            lives_q      <= InitLives;
            score_q      <= '0;
            cnt_q        <= '0;
            move_block_q <= 1'b1;
            hit_q        <= 1'b0;
            goal_q       <= 1'b0;
            invul_q      <= 1'b0;
            over_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            lives_q      <= lives_d;
            score_q      <= score_d;
            cnt_q        <= cnt_d;
            move_block_q <= move_block_d;
            hit_q        <= hit_d;
            goal_q       <= goal_d;
            invul_q      <= invul_d;
            over_q       <= over_d;
        end
    end

    assign bus.frog_col     = col_q;
    assign bus.frog_row     = row_q;
    assign bus.lives        = lives_q;
    assign bus.score        = score_q;
    assign bus.hit_pulse    = hit_q;
    assign bus.goal_pulse   = goal_q;
    assign bus.invulnerable = invul_q;
    assign bus.game_over    = over_q;

endmodule

// File: tb/tb_frog_controller_param.sv
// Directed bench for frog_controller_param: movement, priority, hit/respawn,
// game over, restart, goal scoring with saturation, and async reset.
module tb_frog_controller_param;

    localparam int unsigned COL_W    = 5;
    localparam int unsigned ROW_W    = 4;
    localparam int unsigned NUM_CARS = 4;
    localparam int unsigned LIVES_W  = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    frog_controller_param_if #(.COL_W(5), .ROW_W(4), .NUM_CARS(4), .LIVES_W(2), .SCORE_W(8)) bus ();
    frog_controller_param_if #(.COL_W(5), .ROW_W(4), .NUM_CARS(4), .LIVES_W(2), .SCORE_W(2)) bus2 ();

    frog_controller_param #(
        .NUM_CARS(4), .RESPAWN_CYCLES(4), .RESPAWN_W(3), .SCORE_W(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Second instance with a 2-bit score, driven by the same stimulus.
    frog_controller_param #(
        .NUM_CARS(4), .RESPAWN_CYCLES(4), .RESPAWN_W(3), .SCORE_W(2)
    ) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    assign bus2.btn_left  = bus.btn_left;
    assign bus2.btn_down  = bus.btn_down;
    assign bus2.btn_up    = bus.btn_up;
    assign bus2.btn_right = bus.btn_right;
    assign bus2.restart   = bus.restart;
    assign bus2.car_x_bus = bus.car_x_bus;
    assign bus2.car_y_bus = bus.car_y_bus;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cars_off();
        for (int i = 0; i < NUM_CARS; i++) begin
            bus.car_x_bus[i*COL_W +: COL_W] = 5'd31;
            bus.car_y_bus[i*ROW_W +: ROW_W] = 4'd15;
        end
    endtask

    task automatic set_car(input int idx, input int x, input int y);
        bus.car_x_bus[idx*COL_W +: COL_W] = 5'(x);
        bus.car_y_bus[idx*ROW_W +: ROW_W] = 4'(y);
    endtask

    task automatic set_btn(input logic [3:0] b);  // {left, down, up, right}
        bus.btn_left  = b[3];
        bus.btn_down  = b[2];
        bus.btn_up    = b[1];
        bus.btn_right = b[0];
    endtask

    // One low cycle to re-arm, one pressed cycle, then buttons released (no tick).
    task automatic press(input logic [3:0] b);
        set_btn(4'b0000);
        tick(1);
        set_btn(b);
        tick(1);
        set_btn(4'b0000);
    endtask

    task automatic do_restart();
        bus.restart = 1'b1;
        tick(1);
        bus.restart = 1'b0;
    endtask

    task automatic chk_pos(input string tag, input int c, input int r);
        chk({tag, "_col"}, 32'(bus.frog_col), 32'(c));
        chk({tag, "_row"}, 32'(bus.frog_row), 32'(r));
    endtask

    initial begin
        set_btn(4'b0000);
        bus.restart = 1'b0;
        cars_off();

        // Reset state
        tick(2);
        chk_pos("reset", 10, 14);
        chk("reset_lives", 32'(bus.lives), 3);
        chk("reset_score", 32'(bus.score), 0);
        chk("reset_hit", 32'(bus.hit_pulse), 0);
        chk("reset_goal", 32'(bus.goal_pulse), 0);
        chk("reset_inv", 32'(bus.invulnerable), 0);
        chk("reset_go", 32'(bus.game_over), 0);
        reset = 1'b0;
        tick(1);

        // Hold left 10 cycles: exactly one cell
        set_btn(4'b1000);
        tick(10);
        chk_pos("hold_left", 9, 14);
        set_btn(4'b0000);
        tick(1);
        set_btn(4'b0010);
        tick(1);
        chk_pos("up", 9, 13);
        set_btn(4'b0000);

        // Walk to col 0, then left is ignored
        repeat (9) press(4'b1000);
        chk_pos("at_col0", 0, 13);
        press(4'b1000);
        chk_pos("left_bound", 0, 13);
        press(4'b0001);
        chk_pos("right_after_bound", 1, 13);

        // Restart and priority left > right
        do_restart();
        chk_pos("restart1", 10, 14);
        press(4'b1001);
        chk_pos("prio_lr", 9, 14);

        // Hit then respawn window
        do_restart();
        set_car(0, 10, 13);
        press(4'b0010);
        chk_pos("move_into_car", 10, 13);
        chk("pre_hit", 32'(bus.hit_pulse), 0);
        tick(1);
        chk("hit1_pulse", 32'(bus.hit_pulse), 1);
        chk("hit1_lives", 32'(bus.lives), 2);
        chk_pos("hit1_pos", 10, 14);
        chk("hit1_inv", 32'(bus.invulnerable), 1);
        set_car(0, 10, 14);
        set_btn(4'b1000);
        for (int k = 0; k < 3; k++) begin
            tick(1);
            chk("resp_inv", 32'(bus.invulnerable), 1);
            chk("resp_hit", 32'(bus.hit_pulse), 0);
            chk("resp_lives", 32'(bus.lives), 2);
            chk("resp_col", 32'(bus.frog_col), 10);
        end
        cars_off();
        tick(1);
        chk("resp_end_inv", 32'(bus.invulnerable), 0);
        tick(1);
        chk_pos("resp_held_btn", 10, 14);
        set_btn(4'b0000);

        // Two more hits -> game over
        set_car(0, 10, 14);
        tick(1);
        chk("hit2_lives", 32'(bus.lives), 1);
        chk("hit2_inv", 32'(bus.invulnerable), 1);
        tick(4);
        chk("hit2_back_play", 32'(bus.invulnerable), 0);
        tick(1);
        chk("hit3_pulse", 32'(bus.hit_pulse), 1);
        chk("hit3_lives", 32'(bus.lives), 0);
        chk("hit3_go", 32'(bus.game_over), 1);
        chk("hit3_inv", 32'(bus.invulnerable), 0);
        press(4'b0010);
        chk_pos("go_frozen", 10, 14);
        chk("go_hold", 32'(bus.game_over), 1);
        chk("go_hit_low", 32'(bus.hit_pulse), 0);
        cars_off();
        do_restart();
        chk("rs_lives", 32'(bus.lives), 3);
        chk("rs_score", 32'(bus.score), 0);
        chk("rs_go", 32'(bus.game_over), 0);
        chk_pos("rs_pos", 10, 14);

        // Goal scoring
        repeat (14) press(4'b0010);
        chk_pos("at_row0", 10, 0);
        chk("pre_goal", 32'(bus.goal_pulse), 0);
        tick(1);
        chk("goal_pulse", 32'(bus.goal_pulse), 1);
        chk("goal_score", 32'(bus.score), 1);
        chk_pos("goal_pos", 10, 14);
        tick(1);
        chk("goal_pulse_drop", 32'(bus.goal_pulse), 0);
        for (int g = 0; g < 3; g++) begin
            repeat (14) press(4'b0010);
            tick(1);
        end
        chk("score_wide", 32'(bus.score), 4);
        chk("score_sat", 32'(bus2.score), 3);
        chk("sat_goal_pulse", 32'(bus2.goal_pulse), 1);

        // Async reset mid-respawn (counter at 2)
        do_restart();
        set_car(0, 10, 13);
        press(4'b0010);
        tick(2);
        chk("ar_inv", 32'(bus.invulnerable), 1);
        chk("ar_lives", 32'(bus.lives), 2);
        cars_off();
        #2;
        reset = 1'b1;
        #1;
        chk("ar_inv0", 32'(bus.invulnerable), 0);
        chk("ar_lives3", 32'(bus.lives), 3);
        chk("ar_score0", 32'(bus.score), 0);
        chk_pos("ar_pos", 10, 14);
        chk("ar_hit0", 32'(bus.hit_pulse), 0);
        tick(1);
        reset = 1'b0;
        tick(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard bound on run time.
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
